// File: rtl/axis_capture_packer.sv
// Triggered capture stage: after arm and trigger, packs LANES narrow samples
// into each wide AXI-Stream word and emits cfg_words words, with tlast on the final word.
module axis_capture_packer #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int CNTR_WIDTH       = 20
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_arm,
  input  logic [CNTR_WIDTH-1:0]       cfg_words,
  input  logic                        trig,
  output logic [1:0]                  sts_state,
  output logic [CNTR_WIDTH-1:0]       sts_words,
  output logic                        sts_overflow,
  input  logic [SAMPLE_WIDTH-1:0]     s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam int LANES  = AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [CNTR_WIDTH-1:0]         r_cfg_words;
  logic [CNTR_WIDTH-1:0]         r_words;
  logic                          r_overflow;
  logic [LANE_W-1:0]             r_lane;
  logic [SAMPLE_WIDTH-1:0]       r_pack [LANES-1];
  logic [AXIS_TDATA_WIDTH-1:0]   r_tdata;
  logic                          r_tvalid;
  logic                          r_tlast;

  logic                          w_capturing;
  logic                          w_cap_sample;
  logic                          w_lane_last;
  logic                          w_word_done;
  logic                          w_out_hs;
  logic                          w_out_free;
  logic                          w_load;
  logic                          w_drop;
  logic                          w_load_last;
  logic                          w_arm_ok;
  logic [CNTR_WIDTH-1:0]         w_words_inc;
  logic [AXIS_TDATA_WIDTH-1:0]   w_word;

  assign s_axis_tready = 1'b1;
  assign sts_state     = r_state;
  assign sts_words     = r_words;
  assign sts_overflow  = r_overflow;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

  // The trigger cycle itself captures: a sample arriving with trig becomes lane 0.
  assign w_capturing  = (r_state == S_CAPTURE) || ((r_state == S_ARMED) && trig);
  assign w_cap_sample = w_capturing && s_axis_tvalid;
  assign w_lane_last  = (r_lane == LANE_W'(LANES - 1));
  assign w_word_done  = w_cap_sample && w_lane_last;
  assign w_out_hs     = r_tvalid && m_axis_tready;
  assign w_out_free   = !r_tvalid || m_axis_tready;
  assign w_load       = w_word_done && w_out_free;
  assign w_drop       = w_word_done && !w_out_free;
  assign w_words_inc  = r_words + CNTR_WIDTH'(1);
  assign w_load_last  = w_load && (w_words_inc == r_cfg_words);
  assign w_arm_ok     = (r_state == S_IDLE) && cfg_arm && (cfg_words != '0);

  // The completing sample bypasses the pack registers straight into the top lane.
  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
      always_ff @(posedge aclk) begin
        if (areset) begin
          r_pack[gi] <= '0;
        end else if (w_cap_sample && (r_lane == LANE_W'(gi))) begin
          r_pack[gi] <= s_axis_tdata;
        end
      end
      assign w_word[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_pack[gi];
    end
  endgenerate
  assign w_word[AXIS_TDATA_WIDTH-1 -: SAMPLE_WIDTH] = s_axis_tdata;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_arm_ok) w_state_next = S_ARMED;
      S_ARMED:   if (trig) w_state_next = w_load_last ? S_DRAIN : S_CAPTURE;
      S_CAPTURE: if (w_load_last) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_out_hs && r_tlast) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cfg_words <= '0;
      r_words     <= '0;
      r_overflow  <= 1'b0;
      r_lane      <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
    end else begin
      if (w_arm_ok) begin
        r_cfg_words <= cfg_words;
        r_words     <= '0;
        r_overflow  <= 1'b0;
        r_lane      <= '0;
      end
      if (w_cap_sample) begin
        r_lane <= w_lane_last ? '0 : r_lane + LANE_W'(1);
      end
      if (w_load) begin
        r_words  <= w_words_inc;
        r_tdata  <= w_word;
        r_tlast  <= w_load_last;
        r_tvalid <= 1'b1;
      end else if (w_out_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_capture_packer.sv
// Directed bench for axis_capture_packer: ramp captures, backpressure drop,
// ignored arm/trigger, gappy input and mid-capture reset.
module tb_axis_capture_packer;

  logic        aclk;
  logic        areset;
  logic        cfg_arm;
  logic [19:0] cfg_words;
  logic        trig;
  logic [1:0]  sts_state;
  logic [19:0] sts_words;
  logic        sts_overflow;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int errors = 0;
  int checks = 0;

  logic [63:0] q_data[$];
  logic        q_last[$];
  int          tvalid_cycles = 0;

  axis_capture_packer #(
    .SAMPLE_WIDTH(16),
    .AXIS_TDATA_WIDTH(64),
    .CNTR_WIDTH(20)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_arm(cfg_arm),
    .cfg_words(cfg_words),
    .trig(trig),
    .sts_state(sts_state),
    .sts_words(sts_words),
    .sts_overflow(sts_overflow),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Output monitor: records every handshaken word, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid) tvalid_cycles++;
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
      $display("word %0d: tdata=%h tlast=%0b", q_data.size() - 1, m_axis_tdata, m_axis_tlast);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic cyc;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int s);
    return {16'(s + 3), 16'(s + 2), 16'(s + 1), 16'(s)};
  endfunction

  task automatic arm(input int n);
    cfg_arm   = 1'b1;
    cfg_words = 20'(n);
    cyc;
    cfg_arm   = 1'b0;
  endtask

  // Ramp source: value v advances on each valid cycle; trig accompanies sample trig_at.
  // Downstream ready is low while lo <= v <= hi.
  task automatic ramp(input int first, input int trig_at, input int lo, input int hi,
                      input bit gappy, input int want, input int base, input int max_cyc);
    int v = first;
    bit ph = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      s_axis_tvalid = gappy ? ph : 1'b1;
      s_axis_tdata  = s_axis_tvalid ? 16'(v) : 16'hDEAD;
      trig          = s_axis_tvalid && (v == trig_at);
      m_axis_tready = !((v >= lo) && (v <= hi));
      cyc;
      if (s_axis_tvalid) v++;
      ph = !ph;
      if ((q_data.size() - base >= want) && (sts_state == 2'd0)) break;
    end
    s_axis_tvalid = 1'b0;
    trig          = 1'b0;
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [63:0] d, input logic l);
    chk({tag, "_data"}, (idx < q_data.size()) ? q_data[idx] : 64'hX, d);
    chk({tag, "_last"}, (idx < q_last.size()) ? 64'(q_last[idx]) : 64'hX, 64'(l));
  endtask

  initial begin
    int base;
    int tv0;
    areset        = 1'b1;
    cfg_arm       = 1'b0;
    cfg_words     = '0;
    trig          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    cyc;
    cyc;
    chk("rst_state", 64'(sts_state), 64'd0);
    chk("rst_words", 64'(sts_words), 64'd0);
    chk("rst_ovf", 64'(sts_overflow), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    areset = 1'b0;

    // Test 1: basic capture of 4 words, trigger on sample 10
    arm(4);
    chk("t1_armed", 64'(sts_state), 64'd1);
    base = q_data.size();
    ramp(0, 10, 1, 0, 1'b0, 4, base, 100);
    chk("t1_count", 64'(q_data.size() - base), 64'd4);
    chk_word("t1_w0", base + 0, 64'h000D_000C_000B_000A, 1'b0);
    chk_word("t1_w1", base + 1, 64'h0011_0010_000F_000E, 1'b0);
    chk_word("t1_w2", base + 2, 64'h0015_0014_0013_0012, 1'b0);
    chk_word("t1_w3", base + 3, 64'h0019_0018_0017_0016, 1'b1);
    chk("t1_words", 64'(sts_words), 64'd4);
    chk("t1_state", 64'(sts_state), 64'd0);
    chk("t1_ovf", 64'(sts_overflow), 64'd0);

    // Test 2: backpressure drops word1, capture still delivers 4 words
    arm(4);
    base = q_data.size();
    ramp(0, 10, 10, 20, 1'b0, 4, base, 100);
    m_axis_tready = 1'b1;
    chk("t2_count", 64'(q_data.size() - base), 64'd4);
    chk_word("t2_w0", base + 0, 64'h000D_000C_000B_000A, 1'b0);
    chk_word("t2_w1", base + 1, 64'h0015_0014_0013_0012, 1'b0);
    chk_word("t2_w2", base + 2, 64'h0019_0018_0017_0016, 1'b0);
    chk_word("t2_w3", base + 3, 64'h001D_001C_001B_001A, 1'b1);
    chk("t2_ovf", 64'(sts_overflow), 64'd1);
    chk("t2_words", 64'(sts_words), 64'd4);
    chk("t2_state", 64'(sts_state), 64'd0);

    // Test 3: trig while IDLE and arm with cfg_words=0 are ignored
    tv0  = tvalid_cycles;
    trig = 1'b1;
    s_axis_tvalid = 1'b1;
    cyc;
    trig = 1'b0;
    chk("t3_trig_idle", 64'(sts_state), 64'd0);
    arm(0);
    chk("t3_arm0_state", 64'(sts_state), 64'd0);
    for (int i = 0; i < 6; i++) cyc;
    s_axis_tvalid = 1'b0;
    chk("t3_state", 64'(sts_state), 64'd0);
    chk("t3_no_tvalid", 64'(tvalid_cycles - tv0), 64'd0);
    chk("t3_ovf_kept", 64'(sts_overflow), 64'd1);

    // Test 4: 8 words streamed back to back; cfg_words change after arm has no effect
    arm(8);
    cfg_words = 20'd2;
    chk("t4_ovf_clr", 64'(sts_overflow), 64'd0);
    chk("t4_words_clr", 64'(sts_words), 64'd0);
    base = q_data.size();
    tv0  = tvalid_cycles;
    ramp(100, 100, 1, 0, 1'b0, 8, base, 100);
    chk("t4_count", 64'(q_data.size() - base), 64'd8);
    chk_word("t4_w0", base + 0, 64'h0067_0066_0065_0064, 1'b0);
    for (int k = 1; k < 8; k++) begin
      chk_word($sformatf("t4_w%0d", k), base + k, pack4(100 + 4 * k), k == 7);
    end
    chk("t4_tvalid_cycles", 64'(tvalid_cycles - tv0), 64'd8);
    chk("t4_ovf", 64'(sts_overflow), 64'd0);
    chk("t4_words", 64'(sts_words), 64'd8);

    // Test 5: input valid alternating; gap cycles carry junk data
    arm(2);
    base = q_data.size();
    ramp(200, 200, 1, 0, 1'b1, 2, base, 100);
    chk("t5_count", 64'(q_data.size() - base), 64'd2);
    chk_word("t5_w0", base + 0, 64'h00CB_00CA_00C9_00C8, 1'b0);
    chk_word("t5_w1", base + 1, 64'h00CF_00CE_00CD_00CC, 1'b1);
    chk("t5_state", 64'(sts_state), 64'd0);

    // Test 6: reset while word pending and stalled, then a fresh capture
    arm(4);
    base = q_data.size();
    ramp(296, 300, 0, 100000, 1'b0, 99, base, 12);
    m_axis_tready = 1'b0;
    chk("t6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t6_pre_ovf", 64'(sts_overflow), 64'd1);
    chk("t6_pre_words", 64'(sts_words), 64'd1);
    areset = 1'b1;
    cyc;
    chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_rst_state", 64'(sts_state), 64'd0);
    chk("t6_rst_words", 64'(sts_words), 64'd0);
    chk("t6_rst_ovf", 64'(sts_overflow), 64'd0);
    chk("t6_rst_tdata", m_axis_tdata, 64'd0);
    chk("t6_rst_tready", 64'(s_axis_tready), 64'd1);
    areset = 1'b0;
    m_axis_tready = 1'b1;
    chk("t6_no_words", 64'(q_data.size() - base), 64'd0);
    arm(1);
    base = q_data.size();
    ramp(400, 400, 1, 0, 1'b0, 1, base, 50);
    chk("t6_count", 64'(q_data.size() - base), 64'd1);
    chk_word("t6_w0", base + 0, 64'h0193_0192_0191_0190, 1'b1);
    chk("t6_words", 64'(sts_words), 64'd1);
    chk("t6_state", 64'(sts_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
